alu16: RTL and testbench
========================

ALU16 -- requirements
Module: alu16

Interface
- REQ-001: Parameter WIDTH, default 16, datapath width; all requirements below use WIDTH=16.
- REQ-002: clk  input  1  single clock; rising edge is the only active edge.
- REQ-003: rst_n  input  1  asynchronous, active-low reset.
- REQ-004: Ain  input  16  operand A.
- REQ-005: Bin  input  16  operand B.
- REQ-006: ALUop  input  2  operation select.
- REQ-007: load_s  input  1  status-register load enable, sampled on rising clk.
- REQ-008: out  output  16  combinational result.
- REQ-009: Z  output  1  combinational zero flag for the current result.
- REQ-010: status  output  3  registered flags {V,N,Z}, bit2=V, bit1=N, bit0=Z.

Function
- REQ-011: out and Z SHALL be purely combinational from Ain, Bin and ALUop, with zero clock latency and no dependence on clk, rst_n or load_s.
- REQ-012: ALUop=00 SHALL give out = (Ain + Bin) mod 2^16; the carry-out is discarded.
- REQ-013: ALUop=01 SHALL give out = (Ain - Bin) mod 2^16, in two's complement; a negative result wraps (e.g. 2-4 = 0xFFFE).
- REQ-014: ALUop=10 SHALL give out = Ain & Bin, bitwise.
- REQ-015: ALUop=11 SHALL give out = ~Bin, bitwise; Ain is ignored.
- REQ-016: Z SHALL be 1 exactly when out == 0x0000, for every ALUop.
- REQ-017: The internal N value SHALL equal out[15].
- REQ-018: The internal V value SHALL be signed overflow:
  - add: Ain[15]==Bin[15] and out[15]!=Ain[15];
  - sub: Ain[15]!=Bin[15] and out[15]!=Ain[15];
  - V SHALL be 0 for ALUop 10 and 11.
- REQ-019: On a rising clk with load_s=1 and rst_n=1, status SHALL capture {V,N,Z} of the current combinational result.
- REQ-020: On a rising clk with load_s=0, status SHALL hold its value.
- REQ-021: X/Z values on inputs are not required to propagate meaningfully; with all inputs known, out, Z and status SHALL never be X.

Reset
- REQ-022: Asserting rst_n=0 SHALL clear status to 3'b000 immediately, without waiting for a clock edge.
- REQ-023: While rst_n=0, status SHALL remain 000 regardless of clk and load_s.
- REQ-024: rst_n SHALL NOT affect out or Z, which track the inputs during reset.
- REQ-025: After rst_n deasserts, the first rising clk with load_s=1 SHALL load status normally.
- REQ-026: If reset is asserted during an operation, the in-progress load SHALL be lost and status SHALL read 000.

Verification
- REQ-027: Add: Ain=0x0002, Bin=0x0004, ALUop=00 -> out=0x0006, Z=0.
- REQ-028: Subtract and zero: Ain=0x0004, Bin=0x0002, ALUop=01 -> out=0x0002, Z=0; then Ain=Bin=0x0002, ALUop=01 -> out=0x0000, Z=1.
- REQ-029: AND and NOT:
  - Ain=Bin=0x0004, ALUop=10 -> out=0x0004, Z=0;
  - Ain=0x0002, Bin=0x0004, ALUop=11 -> out=0xFFFB, Z=0.
- REQ-030: Overflow and flags: Ain=0x7FFF, Bin=0x0001, ALUop=00, load_s=1, one rising clk -> out=0x8000, status=3'b110.
- REQ-031: Status hold and reset:
  - after status loads a non-zero value, changing the inputs with load_s=0 over several clocks -> status unchanged;
  - dropping rst_n mid-cycle -> status=000 immediately, with no clock edge.
- REQ-032: Every check SHALL be performed 5 time units after the inputs settle, with no clock edge required for out and Z.

Source files
------------

// File: rtl/alu16.sv
// alu16: combinational add/sub/and/not datapath with a zero flag, plus a
// registered {V,N,Z} status word loaded on demand.
module alu16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] Ain,
  input  logic [WIDTH-1:0] Bin,
  input  logic [1:0]       ALUop,
  input  logic             load_s,
  output logic [WIDTH-1:0] out,
  output logic             Z,
  output logic [2:0]       status
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_AND = 2'b10,
    OP_NOT = 2'b11
  } alu_op_e;

  alu_op_e          op;
  logic [WIDTH-1:0] result;
  logic             ovf;
  logic             neg;

  assign op = alu_op_e'(ALUop);

  // Result and signed-overflow detection for the selected operation
  always_comb begin
    result = '0;
    ovf    = 1'b0;
    case (op)
      OP_ADD: begin
        result = Ain + Bin;
        ovf    = (Ain[WIDTH-1] == Bin[WIDTH-1]) && (result[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_SUB: begin
        result = Ain - Bin;
        ovf    = (Ain[WIDTH-1] != Bin[WIDTH-1]) && (result[WIDTH-1] != Ain[WIDTH-1]);
      end
      OP_AND: result = Ain & Bin;
      OP_NOT: result = ~Bin;
      default: begin
        result = '0;
        ovf    = 1'b0;
      end
    endcase
  end

  assign out = result;
  assign Z   = (result == '0);
  assign neg = result[WIDTH-1];

  // Status word: cleared asynchronously, captures {V,N,Z} when load_s is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status <= '0;
    end else if (load_s) begin
      status <= {ovf, neg, Z};
    end
  end

endmodule

// File: tb/tb_alu16.sv
// tb_alu16: directed and random stimulus against an arithmetic reference model.
module tb_alu16;

  logic        clk;
  logic        rst_n;
  logic [15:0] Ain;
  logic [15:0] Bin;
  logic [1:0]  ALUop;
  logic        load_s;
  logic [15:0] out;
  logic        Z;
  logic [2:0]  status;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [2:0]  exp_status;
  logic        pend_ld;
  logic [2:0]  pend_val;

  alu16 #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .Ain    (Ain),
    .Bin    (Bin),
    .ALUop  (ALUop),
    .load_s (load_s),
    .out    (out),
    .Z      (Z),
    .status (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: signed integer arithmetic; overflow means the true result
  // does not fit a 16-bit signed value.
  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                input logic [1:0] op,
                                output logic [15:0] o, output logic [2:0] fl);
    int sa, sb, r;
    logic v;
    sa = $signed(a);
    sb = $signed(b);
    r  = 0;
    v  = 1'b0;
    case (op)
      2'd0: begin r = sa + sb; o = r[15:0]; v = (r > 32767) || (r < -32768); end
      2'd1: begin r = sa - sb; o = r[15:0]; v = (r > 32767) || (r < -32768); end
      2'd2: o = a & b;
      default: o = ~b;
    endcase
    fl = {v, (o >= 16'h8000), (o == 16'h0000)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: wait for a rising edge, apply inputs 1 unit later, check 5 later.
  task automatic step(input string tag, input logic [15:0] a, input logic [15:0] b,
                      input logic [1:0] op, input logic ld);
    logic [15:0] e_out;
    logic [2:0]  e_fl;
    @(posedge clk);
    if (pend_ld && rst_n) exp_status = pend_val;
    #1;
    Ain = a; Bin = b; ALUop = op; load_s = ld;
    #5;
    model(a, b, op, e_out, e_fl);
    check({tag, ".out"}, out, e_out);
    check({tag, ".Z"}, {15'd0, Z}, {15'd0, e_fl[0]});
    check({tag, ".status"}, {13'd0, status}, {13'd0, exp_status});
    pend_ld  = ld;
    pend_val = e_fl;
  endtask

  initial begin
    rst_n = 1'b0; Ain = '0; Bin = '0; ALUop = 2'b00; load_s = 1'b0;
    exp_status = 3'b000; pend_ld = 1'b0; pend_val = 3'b000;

    // Reset state; datapath still live while in reset, loads ignored
    #1;
    check("reset.status", {13'd0, status}, 16'd0);
    step("rst_add", 16'h1234, 16'h0001, 2'b00, 1'b1);
    step("rst_not", 16'h0000, 16'hFFFF, 2'b11, 1'b1);
    #1 rst_n = 1'b1;

    // Directed vectors
    step("add",   16'h0002, 16'h0004, 2'b00, 1'b0);
    step("sub",   16'h0004, 16'h0002, 2'b01, 1'b0);
    step("subz",  16'h0002, 16'h0002, 2'b01, 1'b1);
    step("and",   16'h0004, 16'h0004, 2'b10, 1'b0);
    step("not",   16'h0002, 16'h0004, 2'b11, 1'b0);
    step("wrap",  16'h0002, 16'h0004, 2'b01, 1'b0);
    step("ovf",   16'h7FFF, 16'h0001, 2'b00, 1'b1);
    step("subov", 16'h8000, 16'h0001, 2'b01, 1'b0);
    check("ovf.status_const", {13'd0, status}, 16'h0006);

    // Hold with load_s low across several changing inputs
    for (int i = 0; i < 6; i++)
      step("hold", 16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
    check("hold.status_const", {13'd0, status}, 16'h0006);

    // Load a new value then kill it with a mid-cycle asynchronous reset
    step("neg", 16'h0000, 16'h0001, 2'b01, 1'b1);
    @(posedge clk);
    if (pend_ld && rst_n) exp_status = pend_val;
    pend_ld = 1'b0;
    #1 load_s = 1'b0;
    #1 check("preload.status", {13'd0, status}, {13'd0, exp_status});
    step("pending", 16'h4000, 16'h4000, 2'b00, 1'b1);
    #1 rst_n = 1'b0;
    exp_status = 3'b000; pend_ld = 1'b0;
    #1 check("async_rst.status", {13'd0, status}, 16'd0);
    step("in_rst", 16'h7FFF, 16'h7FFF, 2'b00, 1'b1);
    #1 rst_n = 1'b1;
    step("post_rst", 16'h8000, 16'h8000, 2'b00, 1'b1);
    step("post_rst2", 16'h0001, 16'h0001, 2'b10, 1'b0);

    // Random traffic
    for (int i = 0; i < 300; i++)
      step("rand", 16'($urandom), 16'($urandom), 2'($urandom), 1'($urandom));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
